// File: rtl/camera_capture_scheduler.sv
// camera_capture_scheduler: periodic/single-shot capture sequencing with tlast completion, stall timeout and recovery reset
module camera_capture_scheduler #(
  parameter int unsigned FRAME_PERIOD = 6666667,
  parameter int unsigned TIMEOUT      = 2500000,
  parameter int unsigned START_HOLD   = 24,
  parameter int unsigned RECOVER_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        single_shot,
  output logic        start_capture,
  output logic        cam_rst,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tlast,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic [15:0] last_pixels
);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, RECOVER} state_t;
  state_t state, state_d;
  logic [31:0] timer, hold_cnt, to_cnt, rec_cnt;
  logic [15:0] beat_cnt;
  logic tick, beat, active, launch, done, tmo, hold_end, rec_end;
  assign tick = enable && timer == FRAME_PERIOD - 1;
  assign beat = mon_tvalid && mon_tready;
  assign busy = state != IDLE;
  always_comb begin
    active   = state == ARM || state == WAIT;
    launch   = state == IDLE && (tick || single_shot);
    done     = active && beat && mon_tlast;
    tmo      = active && !done && to_cnt == TIMEOUT - 1;
    hold_end = state == ARM && hold_cnt == START_HOLD - 1;
    rec_end  = state == RECOVER && rec_cnt == RECOVER_LEN - 1;
    state_d  = launch ? ARM : (done || rec_end) ? IDLE : tmo ? RECOVER : hold_end ? WAIT : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      hold_cnt      <= '0;
      to_cnt        <= '0;
      rec_cnt       <= '0;
      beat_cnt      <= '0;
      start_capture <= 1'b0;
      cam_rst       <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      frame_count   <= '0;
      drop_count    <= '0;
      last_pixels   <= '0;
    end else begin
      state         <= state_d;
      timer         <= (!enable || tick) ? '0 : timer + 32'd1;
      hold_cnt      <= state == ARM ? hold_cnt + 32'd1 : '0;
      to_cnt        <= active ? to_cnt + 32'd1 : '0;
      rec_cnt       <= state == RECOVER ? rec_cnt + 32'd1 : '0;
      beat_cnt      <= launch ? '0 : (active && beat && beat_cnt != 16'hFFFF) ? beat_cnt + 16'd1 : beat_cnt;
      start_capture <= launch ? 1'b1 : (done || tmo || hold_end) ? 1'b0 : start_capture;
      cam_rst       <= tmo ? 1'b1 : rec_end ? 1'b0 : cam_rst;
      frame_done    <= done;
      timeout_err   <= tmo;
      frame_count   <= done ? frame_count + 16'd1 : frame_count;
      last_pixels   <= done ? (beat_cnt == 16'hFFFF ? beat_cnt : beat_cnt + 16'd1) : last_pixels;
      drop_count    <= (tick && busy && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
    end
  end
endmodule

// File: tb/tb_camera_capture_scheduler.sv
// tb_camera_capture_scheduler: directed checks of capture sequencing, drops, timeout and recovery
module tb_camera_capture_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tr = 1'b1;
  logic en [3];
  logic ss [3];
  logic tv [3];
  logic tl [3];
  logic sc [3];
  logic cr [3];
  logic bz [3];
  logic fd [3];
  logic te [3];
  logic [15:0] fc [3];
  logic [15:0] dc [3];
  logic [15:0] lp [3];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  camera_capture_scheduler u0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .single_shot(ss[0]), .start_capture(sc[0]), .cam_rst(cr[0]),
    .mon_tvalid(tv[0]), .mon_tready(tr), .mon_tlast(tl[0]), .busy(bz[0]), .frame_done(fd[0]),
    .timeout_err(te[0]), .frame_count(fc[0]), .drop_count(dc[0]), .last_pixels(lp[0])
  );
  camera_capture_scheduler #(.FRAME_PERIOD(1000), .TIMEOUT(800)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .single_shot(ss[1]), .start_capture(sc[1]), .cam_rst(cr[1]),
    .mon_tvalid(tv[1]), .mon_tready(tr), .mon_tlast(tl[1]), .busy(bz[1]), .frame_done(fd[1]),
    .timeout_err(te[1]), .frame_count(fc[1]), .drop_count(dc[1]), .last_pixels(lp[1])
  );
  camera_capture_scheduler #(.FRAME_PERIOD(100), .TIMEOUT(500)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .single_shot(ss[2]), .start_capture(sc[2]), .cam_rst(cr[2]),
    .mon_tvalid(tv[2]), .mon_tready(tr), .mon_tlast(tl[2]), .busy(bz[2]), .frame_done(fd[2]),
    .timeout_err(te[2]), .frame_count(fc[2]), .drop_count(dc[2]), .last_pixels(lp[2])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    int hi, nd, nt, nl, rem, rise, ncr;
    int lt [3];
    logic prev;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b1;
      ss[i] = 1'b1;
      tv[i] = 1'b1;
      tl[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_flags%0d", i), {27'd0, sc[i], cr[i], bz[i], fd[i], te[i]}, 32'd0);
      check($sformatf("rst_fc%0d", i), {16'd0, fc[i]}, 32'd0);
      check($sformatf("rst_dc%0d", i), {16'd0, dc[i]}, 32'd0);
      check($sformatf("rst_lp%0d", i), {16'd0, lp[i]}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      ss[i] = 1'b0;
      tv[i] = 1'b0;
      tl[i] = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    ss[0] = 1'b1;
    @(negedge clk);
    ss[0] = 1'b0;
    hi = 0;
    nd = 0;
    for (int i = 0; i < 4096; i++) begin
      hi += int'(sc[0]);
      nd += int'(fd[0]);
      tv[0] = 1'b1;
      tl[0] = (i == 4095);
      @(negedge clk);
    end
    tv[0] = 1'b0;
    tl[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nd += int'(fd[0]);
      @(negedge clk);
    end
    check("t2_start_hold", hi, 24);
    check("t2_done_pulses", nd, 1);
    check("t2_frame_count", {16'd0, fc[0]}, 1);
    check("t2_last_pixels", {16'd0, lp[0]}, 4096);
    check("t2_busy_after", {31'd0, bz[0]}, 0);
    en[1] = 1'b1;
    prev = 1'b0;
    nl = 0;
    rem = 0;
    nt = 0;
    for (int j = 1; j <= 3400; j++) begin
      @(negedge clk);
      nt += int'(te[1]);
      if (sc[1] && !prev) begin
        if (nl < 3) lt[nl] = j;
        nl++;
        rem = 300;
      end
      prev = sc[1];
      tv[1] = rem > 0;
      tl[1] = rem == 1;
      if (rem > 0) rem--;
    end
    en[1] = 1'b0;
    check("t3_launches", nl, 3);
    check("t3_launch0", lt[0], 1000);
    check("t3_launch1", lt[1], 2000);
    check("t3_launch2", lt[2], 3000);
    check("t3_frame_count", {16'd0, fc[1]}, 3);
    check("t3_last_pixels", {16'd0, lp[1]}, 300);
    check("t3_drop_count", {16'd0, dc[1]}, 0);
    check("t3_timeouts", nt, 0);
    en[2] = 1'b1;
    prev = 1'b0;
    rise = 0;
    for (int j = 1; j <= 360; j++) begin
      @(negedge clk);
      if (sc[2] && !prev && rise == 0) rise = j;
      prev = sc[2];
      tv[2] = (j == 349);
      tl[2] = (j == 349);
    end
    en[2] = 1'b0;
    check("t4_launch", rise, 100);
    check("t4_drop_count", {16'd0, dc[2]}, 2);
    check("t4_frame_count", {16'd0, fc[2]}, 1);
    check("t4_busy_after", {31'd0, bz[2]}, 0);
    ss[2] = 1'b1;
    @(negedge clk);
    ss[2] = 1'b0;
    check("t5_launch", {31'd0, sc[2]}, 1);
    nt = 0;
    rise = 0;
    ncr = 0;
    for (int k = 1; k <= 540; k++) begin
      if (te[2]) begin
        nt++;
        if (rise == 0) rise = k;
      end
      ncr += int'(cr[2]);
      tv[2] = (k == 505);
      tl[2] = (k == 505);
      @(negedge clk);
    end
    check("t5_timeout_at", rise, 501);
    check("t5_timeout_pulses", nt, 1);
    check("t5_cam_rst_len", ncr, 16);
    check("t5_frame_count", {16'd0, fc[2]}, 1);
    check("t5_busy_after", {31'd0, bz[2]}, 0);
    ss[2] = 1'b1;
    @(negedge clk);
    ss[2] = 1'b0;
    nt = 0;
    nd = 0;
    for (int k = 1; k <= 520; k++) begin
      nt += int'(te[2]);
      nd += int'(fd[2]);
      tv[2] = (k == 500);
      tl[2] = (k == 500);
      @(negedge clk);
    end
    check("t6_done_on_timeout", nd, 1);
    check("t6_no_timeout", nt, 0);
    check("t6_frame_count", {16'd0, fc[2]}, 2);
    check("t6_last_pixels", {16'd0, lp[2]}, 1);
    en[2] = 1'b1;
    prev = 1'b0;
    nl = 0;
    rise = 0;
    for (int j = 1; j <= 150; j++) begin
      @(negedge clk);
      ss[2] = (j == 99);
      if (sc[2] && !prev) begin
        nl++;
        rise = j;
      end
      prev = sc[2];
    end
    check("t6_coincident_launches", nl, 1);
    check("t6_coincident_at", rise, 100);
    check("t6_drop_unchanged", {16'd0, dc[2]}, 2);
    check("t6_busy_mid", {31'd0, bz[2]}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_flags", {29'd0, sc[2], cr[2], bz[2]}, 0);
    check("midrst_fc", {16'd0, fc[2]}, 0);
    rst_n = 1'b1;
    en[2] = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
